// File: rtl/regfile_writeback.sv
// In-order writeback buffer between execute/memory and the register file.
// Drains one entry per cycle through a registered write port and forwards the youngest pending data.
module regfile_writeback #(
   parameter  int DATA_W = 64,
   parameter  int ADDR_W = 5,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_rd,
   input  logic [DATA_W-1:0] req_data,
   input  logic              hold,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              rs1_pending,
   output logic              rs2_pending,
   output logic [DATA_W-1:0] rs1_fwd_data,
   output logic [DATA_W-1:0] rs2_fwd_data,
   output logic [CNT_W-1:0]  count
);

   logic [ADDR_W-1:0] r_rd_mem   [DEPTH];
   logic [DATA_W-1:0] r_data_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_reg_write;
   logic [ADDR_W-1:0] r_rd_out;
   logic [DATA_W-1:0] r_wdata;

   logic              w_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_rs1_hit;
   logic              w_rs2_hit;
   logic [DATA_W-1:0] w_rs1_buf;
   logic [DATA_W-1:0] w_rs2_buf;

   // Writes to x0 complete the handshake but are never buffered.
   assign w_ready = (r_count < CNT_W'(DEPTH));
   assign w_push  = req_valid & w_ready & (req_rd != '0);
   assign w_pop   = (r_count != '0) & ~hold;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_reg_write <= 1'b0;
         r_rd_out    <= '0;
         r_wdata     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd_mem[i]   <= '0;
            r_data_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_rd_mem[r_wr_ptr]   <= req_rd;
            r_data_mem[r_wr_ptr] <= req_data;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_reg_write <= 1'b1;
            r_rd_out    <= r_rd_mem[r_rd_ptr];
            r_wdata     <= r_data_mem[r_rd_ptr];
            r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
         end else begin
            r_reg_write <= 1'b0;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      w_rs1_hit = 1'b0;
      w_rs2_hit = 1'b0;
      w_rs1_buf = '0;
      w_rs2_buf = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CNT_W'(k) < r_count) begin
            if (r_rd_mem[r_rd_ptr + PTR_W'(k)] == rs1) begin
               w_rs1_hit = 1'b1;
               w_rs1_buf = r_data_mem[r_rd_ptr + PTR_W'(k)];
            end
            if (r_rd_mem[r_rd_ptr + PTR_W'(k)] == rs2) begin
               w_rs2_hit = 1'b1;
               w_rs2_buf = r_data_mem[r_rd_ptr + PTR_W'(k)];
            end
         end
      end
   end

   always_comb begin
      rs1_pending  = (rs1 != '0) & (w_rs1_hit | (r_reg_write & (r_rd_out == rs1)));
      rs2_pending  = (rs2 != '0) & (w_rs2_hit | (r_reg_write & (r_rd_out == rs2)));
      rs1_fwd_data = '0;
      rs2_fwd_data = '0;
      if (rs1_pending) rs1_fwd_data = w_rs1_hit ? w_rs1_buf : r_wdata;
      if (rs2_pending) rs2_fwd_data = w_rs2_hit ? w_rs2_buf : r_wdata;
   end

   assign req_ready = w_ready;
   assign RegWrite  = r_reg_write;
   assign rd        = r_rd_out;
   assign WriteData = r_wdata;
   assign count     = r_count;

endmodule
